// File: rtl/rnbip_regfile_ctl.sv
// rnbip_regfile_ctl: RNBIP-2 general-purpose register bank.
// R0 (the accumulator) is always snapshotted onto read port A. Port B
// snapshots any indexed register. Commands are WRITE (four sources), READ,
// XCHG (R0<->Rn in one edge) and CLEAR (one register per cycle).
//
// Handshake: a command is taken on the rising edge where
// cmd_valid && cmd_ready. cmd_ready is a pure function of the FSM state
// (high only in IDLE) and never depends on cmd_valid. There is no queueing:
// a command offered while busy is not stored, and the master keeps it
// presented until it sees cmd_ready.
module rnbip_regfile_ctl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd,
    input  logic [1:0]       src_sel,
    input  logic [AW-1:0]    dst_idx,
    input  logic [AW-1:0]    src_idx,
    input  logic [WIDTH-1:0] or2_in,
    input  logic [WIDTH-1:0] alu_in,
    output logic [WIDTH-1:0] dataout_a,
    output logic [WIDTH-1:0] dataout_b,
    output logic             rd_valid,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [2:0] CMD_WRITE = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_CLEAR = 3'b011;
    localparam logic [2:0] CMD_XCHG  = 3'b100;

    localparam logic [1:0] SRC_R0  = 2'b00;
    localparam logic [1:0] SRC_RN  = 2'b01;
    localparam logic [1:0] SRC_OR2 = 2'b10;
    localparam logic [1:0] SRC_ALU = 2'b11;

    // Highest index as an AW-bit value; the sweep wraps after this one.
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    // Depth widened by one bit so non-power-of-2 range checks are exact.
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_CLEARING = 2'b01
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   clr_cnt;
    logic [AW-1:0]   clr_cnt_nxt;

    logic [WIDTH-1:0] regs     [DEPTH];
    logic [WIDTH-1:0] regs_nxt [DEPTH];

    logic             accept;
    logic             dst_ok;
    logic             src_ok;
    logic [WIDTH-1:0] dst_val;
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] wr_data;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign dbg_state = state;

    // Indices at or above DEPTH exist only when DEPTH is not a power of 2.
    assign dst_ok = ({1'b0, dst_idx} < DEPTH_W);
    assign src_ok = ({1'b0, src_idx} < DEPTH_W);

    // Pre-edge register values; nonexistent registers read as zero.
    always_comb begin
        dst_val = '0;
        src_val = '0;
        if (dst_ok) dst_val = regs[dst_idx];
        if (src_ok) src_val = regs[src_idx];
    end

    // WRITE source selection.
    always_comb begin
        wr_data = '0;
        case (src_sel)
            SRC_R0:  wr_data = regs[0];
            SRC_RN:  wr_data = src_val;
            SRC_OR2: wr_data = or2_in;
            SRC_ALU: wr_data = alu_in;
            default: wr_data = '0;
        endcase
    end

    // Next value of every register: sweep clear, WRITE or XCHG.
    always_comb begin
        regs_nxt = regs;
        if (state == ST_CLEARING) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (AW'(i) == clr_cnt) regs_nxt[i] = '0;
            end
        end else if (accept) begin
            case (cmd)
                CMD_WRITE: begin
                    if (dst_ok) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (AW'(i) == dst_idx) regs_nxt[i] = wr_data;
                        end
                    end
                end
                CMD_XCHG: begin
                    // With dst_idx == 0 both assignments write R0 back to itself.
                    if (dst_ok) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (AW'(i) == dst_idx) regs_nxt[i] = regs[0];
                        end
                        regs_nxt[0] = dst_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register array storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            regs <= regs_nxt;
        end
    end

    // FSM next state: IDLE accepts commands, CLEARING sweeps one index per cycle.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_IDLE: begin
                if (accept && (cmd == CMD_CLEAR)) begin
                    state_nxt   = ST_CLEARING;
                    clr_cnt_nxt = '0;
                end
            end
            ST_CLEARING: begin
                if (clr_cnt == LAST_IDX) begin
                    state_nxt   = ST_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + AW'(1);
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Read snapshots: updated only by an accepted READ, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout_a <= '0;
            dataout_b <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= accept && (cmd == CMD_READ);
            if (accept && (cmd == CMD_READ)) begin
                dataout_a <= regs[0];
                dataout_b <= dst_val;
            end
        end
    end

endmodule

// File: tb/tb_rnbip_regfile_ctl.sv
// Directed bench for rnbip_regfile_ctl: an 8x8 instance (u_a) and a
// 6-deep, 16-bit instance (u_b) sharing clock and reset.
module tb_rnbip_regfile_ctl;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] WR  = 3'b001;
    localparam logic [2:0] RD  = 3'b010;
    localparam logic [2:0] CLR = 3'b011;
    localparam logic [2:0] XCH = 3'b100;

    // clock / reset
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instance A signals (WIDTH 8, DEPTH 8)
    logic       a_valid, a_ready, a_rdv, a_busy;
    logic [2:0] a_cmd;
    logic [1:0] a_sel, a_dbg;
    logic [2:0] a_dst, a_src;
    logic [7:0] a_or2, a_alu, a_douta, a_doutb;

    // instance B signals (WIDTH 16, DEPTH 6)
    logic        b_valid, b_ready, b_rdv, b_busy;
    logic [2:0]  b_cmd;
    logic [1:0]  b_sel, b_dbg;
    logic [2:0]  b_dst, b_src;
    logic [15:0] b_or2, b_alu, b_douta, b_doutb;

    rnbip_regfile_ctl #(.WIDTH(8), .DEPTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd(a_cmd), .src_sel(a_sel), .dst_idx(a_dst), .src_idx(a_src),
        .or2_in(a_or2), .alu_in(a_alu), .dataout_a(a_douta), .dataout_b(a_doutb),
        .rd_valid(a_rdv), .busy(a_busy), .dbg_state(a_dbg)
    );

    rnbip_regfile_ctl #(.WIDTH(16), .DEPTH(6)) u_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd(b_cmd), .src_sel(b_sel), .dst_idx(b_dst), .src_idx(b_src),
        .or2_in(b_or2), .alu_in(b_alu), .dataout_a(b_douta), .dataout_b(b_doutb),
        .rd_valid(b_rdv), .busy(b_busy), .dbg_state(b_dbg)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: present one command to A for one edge, return 1 time unit after it
    task automatic a_issue(input logic [2:0] c, input logic [1:0] s, input logic [2:0] d,
                           input logic [2:0] si, input logic [7:0] o, input logic [7:0] al);
        a_valid = 1'b1; a_cmd = c; a_sel = s; a_dst = d; a_src = si; a_or2 = o; a_alu = al;
        @(posedge clk); #1;
        a_valid = 1'b0; a_cmd = NOP;
    endtask

    task automatic b_issue(input logic [2:0] c, input logic [1:0] s, input logic [2:0] d,
                           input logic [2:0] si, input logic [15:0] o, input logic [15:0] al);
        b_valid = 1'b1; b_cmd = c; b_sel = s; b_dst = d; b_src = si; b_or2 = o; b_alu = al;
        @(posedge clk); #1;
        b_valid = 1'b0; b_cmd = NOP;
    endtask

    int cnt;

    initial begin
        rst_n = 1'b1;
        a_valid = 1'b0; a_cmd = NOP; a_sel = '0; a_dst = '0; a_src = '0; a_or2 = '0; a_alu = '0;
        b_valid = 1'b0; b_cmd = NOP; b_sel = '0; b_dst = '0; b_src = '0; b_or2 = '0; b_alu = '0;

        // T1: asynchronous reset before any clock edge
        #3 rst_n = 1'b0;
        #1;
        check("t1_douta", 32'(a_douta), 32'h0);
        check("t1_doutb", 32'(a_doutb), 32'h0);
        check("t1_rdv",   32'(a_rdv),   32'h0);
        check("t1_ready", 32'(a_ready), 32'h1);
        check("t1_busy",  32'(a_busy),  32'h0);
        check("t1_dbg",   32'(a_dbg),   32'h0);
        check("t1_b_ready", 32'(b_ready), 32'h1);
        @(negedge clk) rst_n = 1'b1;

        // T2: WRITE alu to idx3, READ it on the next cycle
        a_issue(WR, 2'b11, 3'd3, 3'd0, 8'h00, 8'hA5);
        check("t2_wr_rdv", 32'(a_rdv), 32'h0);
        a_issue(RD, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00);
        check("t2_doutb", 32'(a_doutb), 32'hA5);
        check("t2_douta", 32'(a_douta), 32'h00);
        check("t2_rdv",   32'(a_rdv),   32'h1);
        @(posedge clk); #1;
        check("t2_rdv_drop", 32'(a_rdv),   32'h0);
        check("t2_hold_b",   32'(a_doutb), 32'hA5);

        // T3: exchange R0 with R5, exchange with idx0, other write sources
        a_issue(WR, 2'b10, 3'd0, 3'd0, 8'h11, 8'h00);
        a_issue(WR, 2'b10, 3'd5, 3'd0, 8'h22, 8'h00);
        a_issue(XCH, 2'b00, 3'd5, 3'd0, 8'h00, 8'h00);
        check("t3_xchg_holds_b", 32'(a_doutb), 32'hA5);
        a_issue(RD, 2'b00, 3'd5, 3'd0, 8'h00, 8'h00);
        check("t3_douta", 32'(a_douta), 32'h22);
        check("t3_doutb", 32'(a_doutb), 32'h11);
        a_issue(XCH, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
        a_issue(RD, 2'b00, 3'd5, 3'd0, 8'h00, 8'h00);
        check("t3_x0_douta", 32'(a_douta), 32'h22);
        check("t3_x0_doutb", 32'(a_doutb), 32'h11);
        a_issue(WR, 2'b01, 3'd2, 3'd5, 8'h00, 8'h00);
        a_issue(WR, 2'b00, 3'd4, 3'd0, 8'h00, 8'h00);
        a_issue(RD, 2'b00, 3'd2, 3'd0, 8'h00, 8'h00);
        check("t3_src_rn", 32'(a_doutb), 32'h11);
        a_issue(RD, 2'b00, 3'd4, 3'd0, 8'h00, 8'h00);
        check("t3_src_r0", 32'(a_doutb), 32'h22);

        // T4: load all, CLEAR, commands during the sweep are ignored
        for (int i = 0; i < 8; i++) a_issue(WR, 2'b11, 3'(i), 3'd0, 8'h00, 8'h81 + 8'(i));
        a_issue(RD, 2'b00, 3'd6, 3'd0, 8'h00, 8'h00);
        check("t4_pre_a", 32'(a_douta), 32'h81);
        check("t4_pre_b", 32'(a_doutb), 32'h87);
        a_issue(CLR, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t4_busy_%0d", k), 32'(a_busy), 32'h1);
            a_valid = 1'b1; a_cmd = WR; a_sel = 2'b11; a_dst = 3'd1; a_alu = 8'hFF;
            @(posedge clk); #1;
        end
        a_valid = 1'b0; a_cmd = NOP;
        check("t4_busy_end",  32'(a_busy),  32'h0);
        check("t4_ready_end", 32'(a_ready), 32'h1);
        check("t4_hold_b",    32'(a_doutb), 32'h87);
        for (int i = 0; i < 8; i++) begin
            a_issue(RD, 2'b00, 3'(i), 3'd0, 8'h00, 8'h00);
            check($sformatf("t4_clr_%0d", i), 32'(a_doutb), 32'h0);
        end
        check("t4_clr_a", 32'(a_douta), 32'h0);

        // T5: reset in the third sweep cycle aborts the CLEAR
        for (int i = 0; i < 8; i++) a_issue(WR, 2'b11, 3'(i), 3'd0, 8'h00, 8'hC0 + 8'(i));
        a_issue(RD, 2'b00, 3'd6, 3'd0, 8'h00, 8'h00);
        check("t5_pre_b", 32'(a_doutb), 32'hC6);
        a_issue(CLR, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_mid_busy", 32'(a_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_busy",  32'(a_busy),  32'h0);
        check("t5_ready", 32'(a_ready), 32'h1);
        check("t5_douta", 32'(a_douta), 32'h0);
        check("t5_doutb", 32'(a_doutb), 32'h0);
        check("t5_dbg",   32'(a_dbg),   32'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_issue(RD, 2'b00, 3'(i), 3'd0, 8'h00, 8'h00);
            check($sformatf("t5_rst_%0d", i), 32'(a_doutb), 32'h0);
        end
        a_issue(WR, 2'b11, 3'd6, 3'd0, 8'h00, 8'h3C);
        a_issue(RD, 2'b00, 3'd6, 3'd0, 8'h00, 8'h00);
        check("t5_new_cmd", 32'(a_doutb), 32'h3C);

        // T6: DEPTH=6, WIDTH=16 out-of-range indices and self-copy
        b_issue(WR, 2'b11, 3'd5, 3'd0, 16'h0000, 16'h1234);
        b_issue(WR, 2'b11, 3'd7, 3'd0, 16'h0000, 16'hBEEF);
        b_issue(WR, 2'b10, 3'd6, 3'd0, 16'hCAFE, 16'h0000);
        b_issue(XCH, 2'b00, 3'd7, 3'd0, 16'h0000, 16'h0000);
        b_issue(RD, 2'b00, 3'd7, 3'd0, 16'h0000, 16'h0000);
        check("t6_rd7_b", 32'(b_doutb), 32'h0);
        check("t6_rd7_a", 32'(b_douta), 32'h0);
        check("t6_rd7_v", 32'(b_rdv),   32'h1);
        b_issue(RD, 2'b00, 3'd6, 3'd0, 16'h0000, 16'h0000);
        check("t6_rd6_b", 32'(b_doutb), 32'h0);
        b_issue(WR, 2'b01, 3'd5, 3'd5, 16'h0000, 16'h0000);
        b_issue(RD, 2'b00, 3'd5, 3'd0, 16'h0000, 16'h0000);
        check("t6_self_copy", 32'(b_doutb), 32'h1234);
        b_issue(WR, 2'b01, 3'd1, 3'd5, 16'h0000, 16'h0000);
        b_issue(RD, 2'b00, 3'd1, 3'd0, 16'h0000, 16'h0000);
        check("t6_copy_b", 32'(b_doutb), 32'h1234);
        b_issue(CLR, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000);
        cnt = 0;
        while (b_busy && cnt < 20) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("t6_clr_cycles", 32'(cnt), 32'd6);
        b_issue(RD, 2'b00, 3'd5, 3'd0, 16'h0000, 16'h0000);
        check("t6_clr_5", 32'(b_doutb), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
